// File: rtl/alu_pkg.sv
// Shared types and defaults for the start/done ALU responder.
package alu_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_MUL_LATENCY = 3;
    // Wide enough for the largest legal multiply latency (15).
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        RELEASE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_pipe.sv
// Registered multiplier; the first stage loads only when the FSM feeds it,
// and the product is read when the FSM count says it has arrived.
module alu_mul_pipe #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  feed,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned STAGES = MUL_LATENCY - 1;

    logic [RES_W-1:0] stage_q [STAGES];

    // Multiply into stage 0 on feed, then shift the product down the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            if (feed) begin
                stage_q[0] <= RES_W'(a) * RES_W'(b);
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign product = stage_q[STAGES-1];

endmodule

// File: rtl/alu_responder.sv
// DUT-side ALU answering start/done commands with a one-cycle done pulse.
module alu_responder
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result,
    output logic                  busy
);

    localparam int unsigned RES_W = 2 * DATA_W;

    alu_state_t         state, state_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [DATA_W-1:0]  a_q, a_n, b_q, b_n;
    logic [2:0]         op_q, op_n;
    logic               clr_q, clr_n;
    logic [RES_W-1:0]   result_n;
    logic               done_n, busy_n;
    logic [RES_W-1:0]   exec_res_c;
    logic [RES_W-1:0]   mul_prod_c;
    logic               mul_feed_c;

    // Feed the multiplier once, in the first EXEC cycle of a mul command.
    assign mul_feed_c = (state == EXEC) && (op_q == mul_op) &&
                        (count == CNT_W'(MUL_LATENCY));

    alu_mul_pipe #(
        .DATA_W      (DATA_W),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk     (clk),
        .reset   (reset),
        .feed    (mul_feed_c),
        .a       (a_q),
        .b       (b_q),
        .product (mul_prod_c)
    );

    // Result of the captured command, zero-extended to the result width.
    always_comb begin
        exec_res_c = '0;
        case (op_q)
            add_op:  exec_res_c = RES_W'(a_q) + RES_W'(b_q);
            and_op:  exec_res_c = RES_W'(a_q & b_q);
            xor_op:  exec_res_c = RES_W'(a_q ^ b_q);
            mul_op:  exec_res_c = mul_prod_c;
            default: exec_res_c = '0;
        endcase
    end

    // Next-state, operand capture, result and done/busy decisions.
    always_comb begin
        state_n  = state;
        count_n  = count;
        a_n      = a_q;
        b_n      = b_q;
        op_n     = op_q;
        clr_n    = 1'b0;
        result_n = result;
        done_n   = 1'b0;

        // rst_op clears the result one edge after it is accepted.
        if (clr_q) begin
            result_n = '0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    a_n  = A;
                    b_n  = B;
                    op_n = op;
                    case (op)
                        add_op, and_op, xor_op: begin
                            state_n = EXEC;
                            count_n = CNT_W'(1);
                        end
                        mul_op: begin
                            state_n = EXEC;
                            count_n = CNT_W'(MUL_LATENCY);
                        end
                        rst_op: begin
                            state_n = RELEASE;
                            clr_n   = 1'b1;
                        end
                        default: state_n = RELEASE;
                    endcase
                end
            end
            EXEC: begin
                if (!start) begin
                    state_n = IDLE;
                end else if (count == CNT_W'(1)) begin
                    result_n = exec_res_c;
                    done_n   = 1'b1;
                    state_n  = RELEASE;
                end else begin
                    count_n = count - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!start) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            clr_q  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            a_q    <= a_n;
            b_q    <= b_n;
            op_q   <= op_n;
            clr_q  <= clr_n;
            result <= result_n;
            done   <= done_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed cases plus random commands
// checked each cycle against a transaction-level expectation.
module tb_alu_responder;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  A, B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic        exp_done   = 1'b0;
    logic        exp_busy   = 1'b0;
    logic [15:0] exp_result = 16'h0;
    logic        chk_en     = 1'b0;
    logic        prev_done  = 1'b0;

    alu_responder #(.DATA_W(8), .MUL_LATENCY(L)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] o);
        case (o)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        case (o)
            3'b001, 3'b010, 3'b011: return 1;
            3'b100:                 return L;
            default:                return 0;
        endcase
    endfunction

    // Cycle-by-cycle comparison of the DUT against the current expectation.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("done", 16'(done), 16'(exp_done));
            chk("result", result, exp_result);
            chk("busy", 16'(busy), 16'(exp_busy));
            chk("done_twice", 16'(done && prev_done), 16'h0000);
        end
        prev_done = done;
    end

    // One command: start held for edges 0..hold after acceptance, then gap idle edges.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                           input int hold, input int gap);
        int          lat;
        logic [15:0] val;
        lat   = lat_of(o);
        val   = alu_ref(a, b, o);
        A     = a;
        B     = b;
        op    = o;
        start = 1'b1;
        for (int e = 0; e <= hold + 1 + gap; e++) begin
            @(posedge clk);
            #1;
            exp_busy = (e <= hold);
            exp_done = (lat > 0) && (hold >= lat) && (e == lat);
            if (exp_done) exp_result = val;
            if (o == 3'b111 && e == 1) exp_result = 16'h0000;
            start = (e < hold);
            A     = 8'($urandom);
            B     = 8'($urandom);
            op    = 3'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        op    = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 16'(done), 16'h0000);
        chk("reset_result", result, 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0000);
        reset  = 1'b0;
        chk_en = 1'b1;

        run_cmd(8'hFF, 8'hFF, 3'b001, 2, 1);  chk("add_ff", result, 16'h01FE);
        run_cmd(8'hFF, 8'hFF, 3'b100, 4, 0);  chk("mul_ff", result, 16'hFE01);
        run_cmd(8'hF0, 8'h3C, 3'b010, 1, 0);  chk("and", result, 16'h0030);
        run_cmd(8'hF0, 8'h3C, 3'b011, 1, 1);  chk("xor", result, 16'h00CC);
        run_cmd(8'h00, 8'h5A, 3'b001, 1, 0);  chk("add_zero_a", result, 16'h005A);
        run_cmd(8'h00, 8'h00, 3'b100, 3, 0);  chk("mul_zero", result, 16'h0000);
        run_cmd(8'h14, 8'hE9, 3'b100, 3, 0);  chk("mul_1234", result, 16'h1234);
        run_cmd(8'h55, 8'h66, 3'b000, 1, 0);  chk("no_op", result, 16'h1234);
        run_cmd(8'h77, 8'h11, 3'b101, 1, 0);  chk("op_101", result, 16'h1234);
        run_cmd(8'h12, 8'h34, 3'b100, 1, 0);  chk("mul_abort", result, 16'h1234);
        run_cmd(8'h01, 8'h02, 3'b001, 1, 0);  chk("add_after_abort", result, 16'h0003);
        run_cmd(8'h99, 8'h99, 3'b111, 2, 0);  chk("rst_op", result, 16'h0000);
        run_cmd(8'h10, 8'h20, 3'b001, 6, 1);  chk("add_long_hold", result, 16'h0030);
        run_cmd(8'h09, 8'h03, 3'b010, 0, 0);  chk("and_abort_at_exec", result, 16'h0030);

        for (int i = 0; i < 1000; i++) begin
            run_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    $urandom_range(0, L + 2), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a multiply.
        run_cmd(8'hFF, 8'hFF, 3'b100, 4, 0);  chk("mul_before_reset", result, 16'hFE01);
        A     = 8'h21;
        B     = 8'h43;
        op    = 3'b100;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_done", 16'(done), 16'h0000);
        chk("midreset_result", result, 16'h0000);
        chk("midreset_busy", 16'(busy), 16'h0000);
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_result = 16'h0000;
        start      = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_cmd(8'h07, 8'h08, 3'b001, 1, 1);  chk("add_after_reset", result, 16'h000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
